// File: rtl/reg_file.sv
// LEGv8 register file: 31 x 64-bit storage (X0..X30), X31 reads as zero.
// Two combinational read ports, one clocked write port, synchronous reset to index values.
module reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        we3,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa3,
    input  logic [63:0] wd3,
    output logic [63:0] rd1,
    output logic [63:0] rd2
);

    localparam int NumRegs = 31;

    logic [63:0] regs_q [NumRegs];
    logic [63:0] regs_d [NumRegs];

    // X31 has no slot, so a write to address 31 simply matches no entry.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            regs_d[i] = regs_q[i];
            if (we3 && (wa3 == 5'(i))) begin
                regs_d[i] = wd3;
            end
        end
    end

    // Reset wins over a simultaneous write and seeds each register with its index.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumRegs; i++) begin
            if (reset) begin
                regs_q[i] <= 64'(i);
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (ra1 == 5'(i)) begin
                rd1 = regs_q[i];
            end
            if (ra2 == 5'(i)) begin
                rd2 = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Randomised scoreboard bench for reg_file: stimulus pushes expected read data,
// a negedge monitor pops and compares against the live read ports.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [63:0] rd1;
    logic [63:0] rd2;

    typedef struct {
        string       name;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } expectT;

    expectT      scoreQ[$];
    logic [63:0] model [32];
    bit          modelValid = 1'b0;
    int          errorCount = 0;
    int          checkCount = 0;

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] modelRead(input logic [4:0] a);
        return (a == 5'd31) ? 64'd0 : model[a];
    endfunction

    // Drive one cycle's inputs, queue the pre-edge read expectation,
    // then clock once and advance the model by the architectural rules.
    task automatic applyStimulus(input bit rst, input bit we, input logic [4:0] wa,
                                 input logic [63:0] wd, input logic [4:0] r1,
                                 input logic [4:0] r2, input string name);
        expectT e;
        reset = rst;
        we3   = we;
        wa3   = wa;
        wd3   = wd;
        ra1   = r1;
        ra2   = r2;
        if (modelValid) begin
            e.name = name;
            e.exp1 = modelRead(r1);
            e.exp2 = modelRead(r2);
            scoreQ.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 64'(i);
            model[31] = 64'd0;
            modelValid = 1'b1;
        end else if (we && wa != 5'd31) begin
            model[wa] = wd;
        end
        #1;
    endtask

    task automatic checkOutput(input expectT e);
        checkCount++;
        if (rd1 !== e.exp1) begin
            errorCount++;
            $display("[TB] FAIL %s rd1 (ra1=%0d): got %h expected %h", e.name, ra1, rd1, e.exp1);
        end
        checkCount++;
        if (rd2 !== e.exp2) begin
            errorCount++;
            $display("[TB] FAIL %s rd2 (ra2=%0d): got %h expected %h", e.name, ra2, rd2, e.exp2);
        end
    endtask

    // Monitor: read ports are combinational, so mid-cycle is a stable sample point.
    always @(negedge clk) begin
        if (scoreQ.size() > 0) begin
            checkOutput(scoreQ.pop_front());
        end
    end

    initial begin
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  hot;
        reset = 1'b0; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
        #1;

        applyStimulus(1, 0, 0, 0, 0, 0, "bringup");
        for (int a = 0; a < 32; a++) begin
            applyStimulus(0, 0, 0, 0, 5'(a), 5'(31 - a), "resetSweep");
        end

        applyStimulus(0, 1, 10, 64'hFFFF_FFFF_FFFF_FFFF, 10, 11, "basicWritePre");
        applyStimulus(0, 0, 0, 0, 10, 11, "basicWritePost");

        applyStimulus(0, 1, 31, 64'h1234_5678_9ABC_DEF0, 31, 30, "xzrWrite");
        for (int a = 0; a < 32; a++) begin
            applyStimulus(0, 0, 0, 0, 5'(a), 31, "xzrSweep");
        end

        applyStimulus(0, 0, 5, 64'hDEAD_BEEF, 5, 5, "weLowEdge");
        applyStimulus(0, 0, 0, 0, 5, 4, "weLowRead");

        applyStimulus(0, 1, 7, 64'hA5A5, 7, 7, "rdwBefore");
        applyStimulus(0, 0, 0, 0, 7, 7, "rdwAfter");

        applyStimulus(0, 1, 3, 64'h55, 3, 10, "preReset");
        applyStimulus(1, 1, 3, 64'hFF, 3, 10, "resetVsWriteEdge");
        applyStimulus(0, 1, 3, 64'hFF, 3, 10, "resetWinsRead");
        applyStimulus(0, 0, 0, 0, 3, 10, "writeAfterReset");

        hot = 5'd0;
        for (int n = 0; n < 600; n++) begin
            wa = 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 49) == 0), $urandom_range(0, 1), wa, wd,
                          ($urandom_range(0, 1) == 1) ? hot : 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), "random");
            hot = wa;
        end

        applyStimulus(0, 0, 0, 0, 31, 0, "final");
        for (int w = 0; w < 5 && scoreQ.size() > 0; w++) @(negedge clk);
        checkCount++;
        if (scoreQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", scoreQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
